// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: shared widths, funct3 codes, LSU state type and access helpers
package risc_v_mike_pkg;

   localparam int DATA_32_W = 32;
   localparam int FUNCT3_W  = 3;

   typedef enum logic [1:0] {LSU_IDLE, LSU_WAIT, LSU_DONE} t_lsu_state;

   localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
   localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
   localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
   localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
   localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
   localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

   function automatic logic lsu_legal(input logic wr, input logic [FUNCT3_W-1:0] f3, input logic [1:0] off);
      return (f3 == F3_LW) ? off == 2'b00
           : (f3 == F3_LH || (!wr && f3 == F3_LHU)) ? !off[0]
           : (f3 == F3_LB || (!wr && f3 == F3_LBU));
   endfunction

   function automatic logic [DATA_32_W-1:0] lsu_extend(input logic [DATA_32_W-1:0] w, input logic [FUNCT3_W-1:0] f3,
                                                      input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = w[{off[1], 4'b0000} +: 16];
      return (f3 == F3_LB)  ? {{24{b[7]}}, b}
           : (f3 == F3_LBU) ? {24'b0, b}
           : (f3 == F3_LH)  ? {{16{h[15]}}, h}
           : (f3 == F3_LHU) ? {16'b0, h}
           : w;
   endfunction

endpackage

// File: rtl/risc_v_mike_byte_mem.sv
// risc_v_mike_byte_mem: DEPTH x 32 array with byte-enable write and registered read
module risc_v_mike_byte_mem
   import risc_v_mike_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic                 re,
   input  logic [3:0]           be,
   input  logic [AW-1:0]        addr,
   input  logic [DATA_32_W-1:0] wdata,
   output logic [DATA_32_W-1:0] rdata
);

   logic [DATA_32_W-1:0] mem [DEPTH];
   logic [DATA_32_W-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
   end

   always_comb rdata_d = re ? mem[addr] : rdata_q;

   always_ff @(posedge clk) begin
      if (!rst) rdata_q <= '0;
      else      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/risc_v_mike_lsu.sv
// risc_v_mike_lsu: multi-cycle load/store unit with wait-states, byte/half access and error strobe
module risc_v_mike_lsu
   import risc_v_mike_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lsu_req,
   input  logic                 lsu_write,
   input  logic [FUNCT3_W-1:0]  lsu_funct3,
   input  logic [ADDR_W-1:0]    lsu_addr,
   input  logic [DATA_32_W-1:0] lsu_wr_data,
   output logic                 lsu_busy,
   output logic                 lsu_rd_valid,
   output logic [DATA_32_W-1:0] lsu_rd_data,
   output logic                 lsu_err
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int LOW_W = IDX_W + 2;

   t_lsu_state           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [LOW_W-1:0]     addr_q, addr_d;
   logic [FUNCT3_W-1:0]  f3_q, f3_d;
   logic                 write_q, write_d;
   logic [DATA_32_W-1:0] wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [FUNCT3_W-1:0]  ext_f3_q, ext_f3_d;
   logic [1:0]           ext_off_q, ext_off_d;

   logic                 legal, accept, idle;
   logic [LOW_W-1:0]     acc_addr;
   logic [FUNCT3_W-1:0]  acc_f3;
   logic                 acc_write;
   logic [DATA_32_W-1:0] acc_wdata, mem_wdata, mem_rdata;
   logic [3:0]           mem_be;
   logic                 mem_we, mem_re;
   logic                 unused_addr;

   assign unused_addr = ^lsu_addr[ADDR_W-1:LOW_W];

   always_comb begin
      idle      = state_q == LSU_IDLE;
      legal     = lsu_legal(lsu_write, lsu_funct3, lsu_addr[1:0]);
      accept    = idle && lsu_req && legal;
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      f3_d      = f3_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      err_d     = idle && lsu_req && !legal;
      if (accept) begin
         addr_d  = lsu_addr[LOW_W-1:0];
         f3_d    = lsu_funct3;
         write_d = lsu_write;
         wdata_d = lsu_wr_data;
         cnt_d   = 4'(WAIT_STATES);
         state_d = (WAIT_STATES == 0) ? LSU_DONE : LSU_WAIT;
      end else if (state_q == LSU_WAIT) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = (cnt_q == 4'd1) ? LSU_DONE : LSU_WAIT;
      end else if (state_q == LSU_DONE) begin
         state_d = LSU_IDLE;
      end
   end

   // With zero wait-states the access goes straight from IDLE, so the memory sees the live request.
   always_comb begin
      acc_addr  = idle ? lsu_addr[LOW_W-1:0] : addr_q;
      acc_f3    = idle ? lsu_funct3 : f3_q;
      acc_write = idle ? lsu_write : write_q;
      acc_wdata = idle ? lsu_wr_data : wdata_q;
      mem_we    = rst && state_d == LSU_DONE && state_q != LSU_DONE && acc_write;
      mem_re    = rst && state_d == LSU_DONE && state_q != LSU_DONE && !acc_write;
      mem_be    = (acc_f3 == F3_SW) ? 4'hF
                : (acc_f3 == F3_SH) ? (acc_addr[1] ? 4'hC : 4'h3)
                : 4'b0001 << acc_addr[1:0];
      mem_wdata = (acc_f3 == F3_SW) ? acc_wdata
                : (acc_f3 == F3_SH) ? {2{acc_wdata[15:0]}}
                : {4{acc_wdata[7:0]}};
      ext_f3_d  = mem_re ? acc_f3 : ext_f3_q;
      ext_off_d = mem_re ? acc_addr[1:0] : ext_off_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= LSU_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         f3_q      <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         ext_f3_q  <= '0;
         ext_off_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         f3_q      <= f3_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         ext_f3_q  <= ext_f3_d;
         ext_off_q <= ext_off_d;
      end
   end

   risc_v_mike_byte_mem #(.DEPTH(MEM_DEPTH), .AW(IDX_W)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .re    (mem_re),
      .be    (mem_be),
      .addr  (acc_addr[LOW_W-1:2]),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign lsu_busy     = accept || state_q == LSU_WAIT;
   assign lsu_rd_valid = state_q == LSU_DONE && !write_q;
   assign lsu_err      = err_q;
   assign lsu_rd_data  = lsu_extend(mem_rdata, ext_f3_q, ext_off_q);

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// tb_risc_v_mike_lsu: directed bench with a byte-array memory model; unit 0 has 2 wait-states, unit 1 none
module tb_risc_v_mike_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req [2];
   logic        wr [2];
   logic [2:0]  f3 [2];
   logic [31:0] addr [2];
   logic [31:0] wd [2];
   logic        busy [2];
   logic        vld [2];
   logic        err [2];
   logic [31:0] rdd [2];

   bit          e_busy [2];
   bit          e_valid [2];
   bit          e_err [2];
   logic [31:0] last_rd [2];
   logic [7:0]  mem_m [2][4096];
   int          ws [2];
   bit          chk_on;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   risc_v_mike_lsu #(.ADDR_W(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut0 (
      .clk(clk), .rst(rst), .lsu_req(req[0]), .lsu_write(wr[0]), .lsu_funct3(f3[0]),
      .lsu_addr(addr[0]), .lsu_wr_data(wd[0]), .lsu_busy(busy[0]), .lsu_rd_valid(vld[0]),
      .lsu_rd_data(rdd[0]), .lsu_err(err[0]));

   risc_v_mike_lsu #(.ADDR_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut1 (
      .clk(clk), .rst(rst), .lsu_req(req[1]), .lsu_write(wr[1]), .lsu_funct3(f3[1]),
      .lsu_addr(addr[1]), .lsu_wr_data(wd[1]), .lsu_busy(busy[1]), .lsu_rd_valid(vld[1]),
      .lsu_rd_data(rdd[1]), .lsu_err(err[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on)
         for (int u = 0; u < 2; u++) begin
            chk($sformatf("busy%0d", u), {31'b0, busy[u]}, {31'b0, e_busy[u]});
            chk($sformatf("rd_valid%0d", u), {31'b0, vld[u]}, {31'b0, e_valid[u]});
            chk($sformatf("err%0d", u), {31'b0, err[u]}, {31'b0, e_err[u]});
            chk($sformatf("rd_data%0d", u), rdd[u], last_rd[u]);
         end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit legal_m(input bit w, input logic [2:0] f, input logic [31:0] a);
      int n;
      bit ok;
      ok = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      n  = 1 << f[1:0];
      return ok && (a % n == 0);
   endfunction

   function automatic logic [31:0] load_m(input int u, input logic [31:0] a, input logic [2:0] f);
      int n;
      logic [31:0] v;
      n = 1 << f[1:0];
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[u][(a + i) % 4096]) << (8 * i));
      if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic store_m(input int u, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      int n;
      n = 1 << f[1:0];
      for (int i = 0; i < n; i++) mem_m[u][(a + i) % 4096] = d[8*i +: 8];
   endtask

   task automatic access(input int u, input bit w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] lit);
      logic [31:0] m;
      cyc();
      req[u] = 1'b1; wr[u] = w; f3[u] = f; addr[u] = a; wd[u] = d;
      e_valid[u] = 1'b0; e_err[u] = 1'b0;
      if (!legal_m(w, f, a)) begin
         e_busy[u] = 1'b0;
         cyc();
         req[u] = 1'b0; e_err[u] = 1'b1;
         cyc();
         e_err[u] = 1'b0;
      end else begin
         e_busy[u] = 1'b1;
         for (int i = 0; i < ws[u]; i++) cyc();
         cyc();
         e_busy[u] = 1'b0;
         if (w) store_m(u, a, f, d);
         else begin
            m = load_m(u, a, f);
            chk($sformatf("model%0d@%h", u, a), m, lit);
            e_valid[u] = 1'b1;
            last_rd[u] = m;
         end
         cyc();
         req[u] = 1'b0; e_valid[u] = 1'b0;
      end
   endtask

   task automatic aborted_store(input logic [31:0] a, input logic [31:0] d, input int k);
      cyc();
      req[0] = 1'b1; wr[0] = 1'b1; f3[0] = 3'b010; addr[0] = a; wd[0] = d;
      e_busy[0] = 1'b1;
      for (int i = 0; i < k; i++) cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1; req[0] = 1'b0;
      for (int u = 0; u < 2; u++) begin
         e_busy[u] = 1'b0; e_valid[u] = 1'b0; e_err[u] = 1'b0; last_rd[u] = '0;
      end
   endtask

   initial begin
      ws[0] = 2; ws[1] = 0;
      chk_on = 1'b0;
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         req[u] = 1'b0; wr[u] = 1'b0; f3[u] = '0; addr[u] = '0; wd[u] = '0;
         e_busy[u] = 1'b0; e_valid[u] = 1'b0; e_err[u] = 1'b0; last_rd[u] = '0;
      end
      cyc();
      chk_on = 1'b1;
      cyc();
      rst = 1'b1;

      access(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
      access(0, 0, 3'b010, 32'h10, 0, 32'hDEAD_BEEF);
      access(0, 1, 3'b000, 32'h13, 32'h0000_0080, 0);
      access(0, 0, 3'b000, 32'h13, 0, 32'hFFFF_FF80);
      access(0, 0, 3'b100, 32'h13, 0, 32'h0000_0080);
      access(0, 0, 3'b010, 32'h10, 0, 32'h80AD_BEEF);
      access(0, 1, 3'b001, 32'h12, 32'hFFFF_1234, 0);
      access(0, 0, 3'b001, 32'h12, 0, 32'h0000_1234);
      access(0, 0, 3'b010, 32'h10, 0, 32'h1234_BEEF);
      access(0, 1, 3'b001, 32'h14, 32'h0000_8001, 0);
      access(0, 0, 3'b001, 32'h14, 0, 32'hFFFF_8001);
      access(0, 0, 3'b101, 32'h14, 0, 32'h0000_8001);
      access(0, 0, 3'b010, 32'h11, 0, 0);
      access(0, 0, 3'b001, 32'h13, 0, 0);
      access(0, 0, 3'b011, 32'h10, 0, 0);
      access(0, 1, 3'b100, 32'h10, 32'hFFFF_FFFF, 0);
      access(0, 1, 3'b001, 32'h11, 32'hFFFF_FFFF, 0);
      access(0, 0, 3'b010, 32'h10, 0, 32'h1234_BEEF);
      access(0, 1, 3'b010, 32'h1000, 32'h0000_0055, 0);
      access(0, 0, 3'b010, 32'h0, 0, 32'h0000_0055);
      access(0, 1, 3'b010, 32'h20, 32'h1122_3344, 0);
      aborted_store(32'h20, 32'hFFFF_FFFF, 1);
      access(0, 0, 3'b010, 32'h20, 0, 32'h1122_3344);
      aborted_store(32'h20, 32'hFFFF_FFFF, 2);
      access(0, 0, 3'b010, 32'h20, 0, 32'h1122_3344);

      access(1, 1, 3'b010, 32'h8, 32'hA5A5_5A5A, 0);
      access(1, 0, 3'b000, 32'h9, 0, 32'h0000_005A);
      access(1, 0, 3'b000, 32'hA, 0, 32'hFFFF_FFA5);
      access(1, 0, 3'b101, 32'hA, 0, 32'h0000_A5A5);
      access(1, 0, 3'b010, 32'h2, 0, 0);
      access(1, 0, 3'b010, 32'h8, 0, 32'hA5A5_5A5A);

      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
